// File: rtl/dtc_vote_pkg.sv
// -----------------------------------------------------------------------------
// dtc_vote_pkg
// Shared definitions for the decision-tree vote collector.
//   CODE_W      width of a classifier output code
//   NUM_CLASS   number of known classes (indices 0..10)
//   CLASS_W     width of a class index
//   CLASS_NONE  class index reported when no known code was seen
//   CODE_TABLE  classifier code for each class index
//   vote_state_t  collector FSM states
// -----------------------------------------------------------------------------
package dtc_vote_pkg;

    localparam int CODE_W    = 7;
    localparam int NUM_CLASS = 11;
    localparam int CLASS_W   = 4;

    localparam logic [CLASS_W-1:0] CLASS_NONE = 4'hF;

    // Packed table: the first entry in the concatenation is the highest
    // index, so the list reads from class 10 down to class 0.
    localparam logic [NUM_CLASS-1:0][CODE_W-1:0] CODE_TABLE = {
        7'b0100001,
        7'b0111001,
        7'b0000111,
        7'b0100111,
        7'b0101111,
        7'b0011111,
        7'b0111111,
        7'b1110011,
        7'b1011011,
        7'b0110111,
        7'b0000000
    };

    typedef enum logic [1:0] {
        COLLECT,
        REDUCE,
        PRESENT
    } vote_state_t;

endpackage

// File: rtl/dtc_code_lookup.sv
// -----------------------------------------------------------------------------
// dtc_code_lookup
// Purely combinational translation of a classifier code into a class index.
//   code       in   CODE_W   classifier output code
//   hit        out  1        code matches a table entry
//   class_idx  out  CLASS_W  matching class index, CLASS_NONE on a miss
// -----------------------------------------------------------------------------
module dtc_code_lookup
    import dtc_vote_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic               hit,
    output logic [CLASS_W-1:0] class_idx
);

    // Compare the incoming code against every table entry in parallel.
    // Table entries are all distinct, so at most one can match and the
    // loop order does not matter.
    always_comb begin
        hit       = 1'b0;
        class_idx = CLASS_NONE;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (code == CODE_TABLE[i]) begin
                hit       = 1'b1;
                class_idx = CLASS_W'(i);
            end
        end
    end

endmodule

// File: rtl/dtc_vote_collector.sv
// -----------------------------------------------------------------------------
// dtc_vote_collector
// Collects WINDOW classifier codes, counts them per class, then scans the
// counts to find the majority class and presents it on a valid/ready stream.
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   clear        in   1      synchronous abort, drops any partial or held result
//   in_valid     in   1      code present on in_code
//   in_ready     out  1      collector can accept a code
//   in_code      in   7      classifier output code
//   out_valid    out  1      vote result valid
//   out_ready    in   1      downstream accepts the result
//   out_class    out  4      winning class index, 4'hF when no known code seen
//   out_count    out  CNT_W  vote count of the winner
//   out_unknown  out  1      an unknown code was seen in this window
//   out_margin   out  CNT_W  winner count minus runner-up count
//                            (only when DTC_VOTE_MARGIN_EN is defined)
// Optional feature macro: DTC_VOTE_MARGIN_EN
// -----------------------------------------------------------------------------
module dtc_vote_collector
    import dtc_vote_pkg::*;
#(
    parameter  int WINDOW = 8,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_unknown
`ifdef DTC_VOTE_MARGIN_EN
    ,
    output logic [CNT_W-1:0]   out_margin
`endif
);

    vote_state_t        state;
    vote_state_t        state_next;

    logic [CNT_W-1:0]   counts [NUM_CLASS];
    logic [CNT_W-1:0]   sample_cnt;
    logic [CLASS_W-1:0] scan_idx;
    logic [CLASS_W-1:0] best_class;
    logic [CNT_W-1:0]   best_count;
    logic               unknown_flag;
`ifdef DTC_VOTE_MARGIN_EN
    logic [CNT_W-1:0]   runner_count;
`endif

    logic               lookup_hit;
    logic [CLASS_W-1:0] lookup_class;
    logic               accept;
    logic               release_result;
    logic               last_sample;
    logic               scan_done;
    logic [CNT_W-1:0]   scan_count;

    dtc_code_lookup u_lookup (
        .code      (in_code),
        .hit       (lookup_hit),
        .class_idx (lookup_class)
    );

    assign accept         = in_valid && in_ready;
    assign release_result = (state == PRESENT) && out_ready && !clear;
    assign last_sample    = (sample_cnt == CNT_W'(WINDOW - 1));
    assign scan_done      = (scan_idx == CLASS_W'(NUM_CLASS - 1));

    // Select the counter currently being examined by the reduce scan.
    // Written as a compare loop so an index past the table reads as zero.
    always_comb begin
        scan_count = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (scan_idx == CLASS_W'(i)) begin
                scan_count = counts[i];
            end
        end
    end

    // State register. Reset drops straight back to COLLECT no matter how far
    // through a window or scan we were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. clear overrides everything else and forces COLLECT;
    // otherwise the window fills, the scan walks all classes, and the result
    // is held until the downstream takes it.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (accept && last_sample) state_next = REDUCE;
                REDUCE:  if (scan_done)             state_next = PRESENT;
                PRESENT: if (out_ready)             state_next = COLLECT;
                default:                            state_next = COLLECT;
            endcase
        end
    end

    // Output decode. in_ready is also dropped during clear so a code offered
    // in that cycle is never taken. Result fields read as their idle values
    // outside PRESENT, and a zero best count means no known code was seen.
    always_comb begin
        in_ready    = (state == COLLECT) && !clear;
        out_valid   = (state == PRESENT);
        out_class   = CLASS_NONE;
        out_count   = '0;
        out_unknown = 1'b0;
`ifdef DTC_VOTE_MARGIN_EN
        out_margin  = '0;
`endif
        if (state == PRESENT) begin
            out_unknown = unknown_flag;
            if (best_count != '0) begin
                out_class = best_class;
                out_count = best_count;
`ifdef DTC_VOTE_MARGIN_EN
                out_margin = best_count - runner_count;
`endif
            end
        end
    end

    // Datapath: per-class counters during COLLECT, the ascending best-count
    // scan during REDUCE. A strict greater-than keeps the lowest index on a
    // tie. When a new best appears, the old best becomes the runner-up;
    // otherwise a count can still beat the current runner-up on its own.
    // Both clear and a completed output handshake wipe everything so the
    // next window starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                counts[i] <= '0;
            end
            sample_cnt   <= '0;
            scan_idx     <= '0;
            best_class   <= '0;
            best_count   <= '0;
            unknown_flag <= 1'b0;
`ifdef DTC_VOTE_MARGIN_EN
            runner_count <= '0;
`endif
        end else if (clear || release_result) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                counts[i] <= '0;
            end
            sample_cnt   <= '0;
            scan_idx     <= '0;
            best_class   <= '0;
            best_count   <= '0;
            unknown_flag <= 1'b0;
`ifdef DTC_VOTE_MARGIN_EN
            runner_count <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (lookup_hit) begin
                            for (int i = 0; i < NUM_CLASS; i++) begin
                                if (lookup_class == CLASS_W'(i)) begin
                                    counts[i] <= counts[i] + CNT_W'(1);
                                end
                            end
                        end else begin
                            unknown_flag <= 1'b1;
                        end
                    end
                end
                REDUCE: begin
                    scan_idx <= scan_idx + CLASS_W'(1);
                    if (scan_count > best_count) begin
                        best_count   <= scan_count;
                        best_class   <= scan_idx;
`ifdef DTC_VOTE_MARGIN_EN
                        runner_count <= best_count;
                    end else if (scan_count > runner_count) begin
                        runner_count <= scan_count;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_vote_collector.sv
// -----------------------------------------------------------------------------
// tb_dtc_vote_collector
// Self-checking bench for dtc_vote_collector with WINDOW=8. Each driven code
// updates a bench-side vote model; when a window completes, the expected
// result is pushed onto a queue and a monitor pops and compares it when the
// DUT hands the result over.
// -----------------------------------------------------------------------------
module tb_dtc_vote_collector;

    localparam int WIN   = 8;
    localparam int CW    = $clog2(WIN + 1);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_code;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_class;
    logic [CW-1:0] out_count;
    logic          out_unknown;
`ifdef DTC_VOTE_MARGIN_EN
    logic [CW-1:0] out_margin;
`endif

    typedef struct {
        int cls;
        int cnt;
        int unk;
        int margin;
    } exp_t;

    exp_t expq[$];

    int check_count = 0;
    int fail_count  = 0;

    int model_cnt [11];
    int model_unk;
    int model_n;

    logic [6:0] tb_codes [12];

    dtc_vote_collector #(.WINDOW(WIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_count   (out_count),
        .out_unknown (out_unknown)
`ifdef DTC_VOTE_MARGIN_EN
        ,
        .out_margin  (out_margin)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Bench-side class lookup, independent of the design's package.
    function automatic int classOf(input logic [6:0] c);
        for (int i = 0; i < 11; i++) begin
            if (tb_codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 11; i++) model_cnt[i] = 0;
        model_unk = 0;
        model_n   = 0;
    endtask

    // Fold one accepted code into the model; on the last sample of a window
    // work out the winner, its count and the margin to the next-highest
    // class, then queue that as the expected result.
    task automatic modelAccept(input logic [6:0] c);
        int k;
        int best;
        int best_c;
        int second;
        exp_t e;
        k = classOf(c);
        if (k >= 0) model_cnt[k]++;
        else model_unk = 1;
        model_n++;
        if (model_n == WIN) begin
            best   = -1;
            best_c = 0;
            for (int i = 0; i < 11; i++) begin
                if (model_cnt[i] > best_c) begin
                    best_c = model_cnt[i];
                    best   = i;
                end
            end
            second = 0;
            for (int i = 0; i < 11; i++) begin
                if (i != best && model_cnt[i] > second) second = model_cnt[i];
            end
            e.cls    = (best < 0) ? 15 : best;
            e.cnt    = best_c;
            e.unk    = model_unk;
            e.margin = best_c - second;
            expq.push_back(e);
            modelReset();
        end
    endtask

    // Offer one code and wait (bounded) until the collector takes it.
    task automatic applyStimulus(input logic [6:0] code);
        int n;
        n = 0;
        in_code  = code;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        modelAccept(code);
    endtask

    task automatic sendRepeat(input logic [6:0] code, input int times);
        for (int i = 0; i < times; i++) applyStimulus(code);
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, expq.size(), 0);
    endtask

    // Monitor: compare each result the DUT hands over with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready && !clear) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_result", int'(out_valid), 0);
            end else begin
                e = expq.pop_front();
                checkOutput("out_class", int'(out_class), e.cls);
                checkOutput("out_count", int'(out_count), e.cnt);
                checkOutput("out_unknown", int'(out_unknown), e.unk);
`ifdef DTC_VOTE_MARGIN_EN
                checkOutput("out_margin", int'(out_margin), e.margin);
`endif
            end
        end
    end

    initial begin
        int n;
        int pick;

        tb_codes[0]  = 7'b0000000;
        tb_codes[1]  = 7'b0110111;
        tb_codes[2]  = 7'b1011011;
        tb_codes[3]  = 7'b1110011;
        tb_codes[4]  = 7'b0111111;
        tb_codes[5]  = 7'b0011111;
        tb_codes[6]  = 7'b0101111;
        tb_codes[7]  = 7'b0100111;
        tb_codes[8]  = 7'b0000111;
        tb_codes[9]  = 7'b0111001;
        tb_codes[10] = 7'b0100001;
        tb_codes[11] = 7'b1111110;
        modelReset();

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;

        #13;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_class", int'(out_class), 15);
        checkOutput("rst_out_count", int'(out_count), 0);
        checkOutput("rst_out_unknown", int'(out_unknown), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);

        $display("[TB] majority window with latency check");
        sendRepeat(7'b0110111, 5);
        sendRepeat(7'b1011011, 3);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", n, 11);
        waitDrain("drain_majority");

        $display("[TB] tie goes to lowest index");
        sendRepeat(7'b0000111, 4);
        sendRepeat(7'b0100001, 4);
        waitDrain("drain_tie");

        $display("[TB] all unknown codes");
        sendRepeat(7'b1111111, 8);
        waitDrain("drain_unknown");

        $display("[TB] mixed unknown with tie at index 0");
        sendRepeat(7'b0000000, 3);
        sendRepeat(7'b1111111, 2);
        sendRepeat(7'b0111111, 3);
        waitDrain("drain_mixed");

        $display("[TB] single class fills window");
        sendRepeat(7'b0100111, 8);
        waitDrain("drain_single");

        $display("[TB] backpressure in PRESENT");
        out_ready = 1'b0;
        sendRepeat(7'b0101111, 6);
        sendRepeat(7'b0011111, 2);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_valid_rise", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", int'(out_valid), 1);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            if (expq.size() != 0) begin
                checkOutput("bp_class", int'(out_class), expq[0].cls);
                checkOutput("bp_count", int'(out_count), expq[0].cnt);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_restart_ready", int'(in_ready), 1);
        checkOutput("bp_restart_valid", int'(out_valid), 0);
        checkOutput("bp_queue", expq.size(), 0);

        $display("[TB] clear mid-window");
        sendRepeat(7'b0111001, 3);
        in_code  = 7'b0110111;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        checkOutput("clear_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        modelReset();
        sendRepeat(7'b0111001, 8);
        waitDrain("drain_clear");

        $display("[TB] reset during REDUCE");
        sendRepeat(7'b0110111, 8);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(out_valid), 0);
        checkOutput("mid_rst_class", int'(out_class), 15);
        expq.delete();
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_in_ready", int'(in_ready), 1);
        sendRepeat(7'b0000111, 8);
        waitDrain("drain_after_reset");

        $display("[TB] random windows");
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < WIN; s++) begin
                pick = $urandom_range(0, 11);
                applyStimulus(tb_codes[pick]);
            end
            waitDrain("drain_random");
        end

        repeat (20) @(posedge clk);
        #1;
        checkOutput("final_idle_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dtc_vote_collector.md
Name: dtc_vote_collector

Overview:
- Sink-side consumer of the 7-bit class codes produced by our decision-tree classifiers (dtc_split*).
- Accepts one code per valid/ready handshake and maps it to a class index.
- Keeps per-class counts over a window of WINDOW samples, then reduces them to a majority-vote winner.
- Presents the winner on a valid/ready output stream.

Parameters:
- WINDOW, 8, number of accepted codes per vote; legal range 1..255.
- CNT_W, $clog2(WINDOW+1), width of each per-class counter and of out_count; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort: empties counters, returns to COLLECT
- in_valid  in  1  code present on in_code
- in_ready  out  1  collector can accept a code
- in_code  in  7  classifier output code
- out_valid  out  1  vote result valid
- out_ready  in  1  downstream accepts the result
- out_class  out  4  winning class index 0..10, or 4'hF if no known code was seen
- out_count  out  CNT_W  vote count of the winner (0 when out_class=4'hF)
- out_unknown  out  1  at least one unknown code was seen in this window

Behaviour:
- Code table: index 0..10 = 7'b0000000, 0110111, 1011011, 1110011, 0111111, 0011111, 0101111, 0100111, 0000111, 0111001, 0100001.
- Any other code is UNKNOWN. UNKNOWN codes are counted toward the window length but are not vote-eligible; each one sets the sticky unknown flag.
- Reset (async, rst_n=0) state:
  - state=COLLECT, all counters, sample count, scan index, best registers and unknown flag = 0.
  - out_valid=0, out_class=4'hF, out_count=0, out_unknown=0; in_ready=1 once rst_n is released.
- FSM states:
  - COLLECT: in_ready=1. Each in_valid&in_ready cycle increments the matching class counter (or sets the unknown flag) and the sample count. Accepting sample number WINDOW moves to REDUCE on the same edge.
  - REDUCE: in_ready=0. One cycle per index 0..10, in ascending order. The best register updates only when count[i] > best_count (strict), so ties go to the lowest index. After index 10, move to PRESENT.
  - PRESENT: out_valid=1. out_class, out_count and out_unknown are held stable until out_valid&out_ready. On that handshake: counters, sample count and flag clear, and the state returns to COLLECT.
- Latency: last sample accepted at edge t; out_valid rises after edge t+11 (11 REDUCE cycles). A new window can start accepting in the cycle after the output handshake.
- No winner: if best_count is 0 at the end of REDUCE, out_class=4'hF and out_count=0.
- Counter width: counters cannot overflow, because each is bounded by WINDOW.
- clear priority: clear wins over both handshakes in any state. Any pending result is dropped, out_valid deasserts the next cycle, and a code offered during the clear cycle is not accepted (in_ready=0 in that cycle).
- Reset mid-window or mid-REDUCE: all partial state is discarded immediately.
- WINDOW=1: every accepted code produces a result.

Optional Feature:
- Macro DTC_VOTE_MARGIN_EN.
- When defined:
  - adds output out_margin [CNT_W-1:0] = winner count minus runner-up count.
  - The runner-up is tracked in the same REDUCE scan: when a new best is found, the old best demotes to runner-up.
  - Reset value is 0; the output is held with the result in PRESENT.
  - Tie for first gives margin 0; a single-class window gives margin = winner count.
- When undefined: the port and the runner-up register are absent; behaviour is otherwise identical.

Decomposition:
- Package dtc_vote_pkg:
  - CODE_W=7, NUM_CLASS=11, CLASS_W=4, CLASS_NONE=4'hF
  - the 11-entry code table constant
  - the state enum {COLLECT, REDUCE, PRESENT}
- Sub-module dtc_code_lookup: purely combinational in_code -> {hit, class index}, implemented from the package table.

Test Plan:
- WINDOW=8; codes 0110111 x5, 1011011 x3, out_ready=1 -> out_class=1, out_count=5, out_unknown=0; out_valid rises 11 cycles after the 8th accept.
- WINDOW=4; codes 0000111, 0100001, 0000111, 0100001 (tie) -> out_class=8 (lowest index), out_count=2; with DTC_VOTE_MARGIN_EN, out_margin=0.
- WINDOW=4; four codes 1111111 -> out_class=4'hF, out_count=0, out_unknown=1.
- Backpressure: hold out_ready=0 for 20 cycles in PRESENT -> outputs stable and in_ready=0 throughout; the next window starts the cycle after out_ready=1.
- clear asserted after 3 of 8 samples with in_valid=1 -> that code is not accepted; the next 8 codes (all 0111001) give out_class=9, out_count=8.
- rst_n pulsed low during REDUCE -> out_valid=0, in_ready=1 after release; the following window reports only the new samples.
